input_char_ctrl: RTL and testbench
==================================

// Module: input_char_ctrl
//
// PURPOSE
//   Input-device front end for the Basic Computer's 8-bit input register (INPR).
//   Accepts characters from a keyboard/terminal source over a valid/ready handshake
//   and buffers them in a small FIFO. Transfers one character at a time into INPR
//   by driving its load/in_data pins, and owns the FGI input flag. The CPU clears
//   FGI (INP / interrupt service) to release the next character. Also produces the
//   input interrupt request (FGI & IEN).
//
// PARAMETERS
//   DEPTH   4   FIFO entries; power of 2, >= 2
//   DATA_W  8   character width; equals INPR width
//   BUS_W   16  width of INPR in_data; upper BUS_W-DATA_W bits driven 0
//
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   kb_valid   in   1       source presents a character on kb_data
//   kb_data    in   DATA_W  character from source
//   kb_ready   out  1       FIFO can accept; transfer when kb_valid & kb_ready
//   inpr_load  out  1       load strobe to INPR
//   inpr_data  out  BUS_W   {0, character} to INPR in_data
//   fgi        out  1       input flag: INPR holds an unread character
//   fgi_clr    in   1       CPU consumed INPR; clear FGI
//   ien        in   1       interrupt enable from CPU
//   irq_in     out  1       fgi & ien, combinational
//   fifo_cnt   out  $clog2(DEPTH)+1  current FIFO occupancy
//
// BEHAVIOUR
//   Reset (async, rst_n=0): FIFO emptied (cnt=0, ptrs=0), state=IDLE,
//     fgi=0, inpr_load=0, inpr_data=0, kb_ready=1 after release.
//   FIFO: kb_ready = (cnt != DEPTH); push on kb_valid & kb_ready.
//     Pointers wrap modulo DEPTH. Push and pop in the same cycle leave cnt
//     unchanged. Push is blocked when full even if a pop occurs that cycle.
//   FSM (registered, 3 states):
//     IDLE: if cnt>0 and fgi=0 -> LOAD; else stay.
//     LOAD: inpr_load=1 for exactly this one cycle; inpr_data={0,head}.
//       At the edge ending LOAD: pop head, set fgi<=1, -> WAIT.
//     WAIT: if fgi_clr -> fgi<=0, -> IDLE; else stay.
//   Latency: a byte pushed into an empty FIFO at edge E0 (with fgi=0)
//     gives LOAD during E1..E2. INPR captures it at E2; fgi=1 after E2.
//   After fgi_clr at edge Ec, the next LOAD starts at Ec+1 at the earliest.
//     Minimum spacing is 3 cycles per character.
//   fgi_clr while fgi=0 (IDLE/LOAD): ignored, no state change.
//   fgi_clr and a push in the same cycle: both take effect.
//   inpr_load is never asserted while fgi=1. INPR is never overwritten before
//     the CPU clears FGI.
//   inpr_data holds its last value outside LOAD (INPR ignores it then).
//   inc/clr are never driven to INPR by this block.
//   Reset mid-LOAD or mid-WAIT: buffered characters are discarded, fgi drops
//     immediately, inpr_load drops immediately.
//
// TESTING
//   1 Reset: rst_n=0 mid-run -> fgi=0, inpr_load=0, fifo_cnt=0, kb_ready=1 at once.
//   2 Single char 0x41 at E0, fgi_clr=0 -> inpr_load=1 only during E1..E2,
//     inpr_data=16'h0041, fgi=1 after E2, fifo_cnt back to 0, irq_in=ien.
//   3 Back-pressure: fgi held, push 0x10..0x15 back-to-back -> 0x10 into INPR,
//     0x11..0x14 buffered (cnt=4), kb_ready=0, 0x15 stalled, no extra inpr_load.
//   4 Drain order: from test 3 pulse fgi_clr each time fgi=1 -> INPR loads
//     0x11,0x12,0x13,0x14,0x15 in order; no loss or duplicate; 3-cycle minimum
//     spacing.
//   5 Wrap/simultaneous: 20 chars with random fgi_clr timing, pushes overlapping
//     pops -> output sequence equals input sequence, cnt never exceeds 4 or
//     goes below 0.
//   6 Spurious fgi_clr in IDLE with cnt=0 -> no change; then push 0xFF ->
//     normal LOAD, inpr_data=16'h00FF.

Source files
------------

// File: rtl/input_char_ctrl_if.sv
// Handshake bundle between the keyboard source / CPU side and the INPR front end.
// The controller uses the slave modport; the source/CPU side uses master.
interface input_char_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int BUS_W  = 16
);
    logic                     kb_valid;
    logic [DATA_W-1:0]        kb_data;
    logic                     kb_ready;
    logic                     inpr_load;
    logic [BUS_W-1:0]         inpr_data;
    logic                     fgi;
    logic                     fgi_clr;
    logic                     ien;
    logic                     irq_in;
    logic [$clog2(DEPTH):0]   fifo_cnt;

    modport master (
        output kb_valid, kb_data, fgi_clr, ien,
        input  kb_ready, inpr_load, inpr_data, fgi, irq_in, fifo_cnt
    );

    modport slave (
        input  kb_valid, kb_data, fgi_clr, ien,
        output kb_ready, inpr_load, inpr_data, fgi, irq_in, fifo_cnt
    );
endinterface

// File: rtl/input_char_ctrl.sv
// Basic Computer input front end: buffers keyboard characters in a small FIFO and
// hands them one at a time to INPR, owning the FGI flag and the input interrupt.
module input_char_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int BUS_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    input_char_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;
    logic                push;
    logic                pop;
    logic                fgi_r;
    logic                load_r;
    logic [BUS_W-1:0]    data_r;

    // Full blocks a push even when the head is leaving this same cycle.
    assign bus.kb_ready  = (cnt != CW'(DEPTH));
    assign push          = bus.kb_valid && bus.kb_ready;
    assign pop           = (state == LOAD);
    assign bus.fifo_cnt  = cnt;
    assign bus.fgi       = fgi_r;
    assign bus.inpr_load = load_r;
    assign bus.inpr_data = data_r;
    assign bus.irq_in    = fgi_r && bus.ien;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.kb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // The head is presented during LOAD and retired at the edge that ends it,
    // so INPR and the FIFO pointer move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            fgi_r  <= 1'b0;
            load_r <= 1'b0;
            data_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt != '0 && !fgi_r) begin
                        state  <= LOAD;
                        load_r <= 1'b1;
                        data_r <= BUS_W'(mem[rd_ptr]);
                    end
                end
                LOAD: begin
                    state  <= WAIT;
                    load_r <= 1'b0;
                    fgi_r  <= 1'b1;
                end
                WAIT: begin
                    if (bus.fgi_clr) begin
                        state <= IDLE;
                        fgi_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    load_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_input_char_ctrl.sv
// Directed bench for input_char_ctrl: a negedge scoreboard tracks every accepted
// character and checks INPR loads, occupancy and flag behaviour.
module tb_input_char_ctrl;
    logic clk;
    logic rst_n;

    input_char_ctrl_if #(.DEPTH(4), .DATA_W(8), .BUS_W(16)) bus ();

    input_char_ctrl #(.DEPTH(4), .DATA_W(8), .BUS_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_loads = 0;
    int          cyc     = 0;
    int          last_load = -100;
    logic [15:0] last_data = '0;
    logic [7:0]  exp_q [$];
    logic [7:0]  send_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected characters are queued at acceptance and popped at each load.
    always @(negedge clk) begin
        int          occ;
        logic [15:0] exp_d;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            last_load = -100;
        end else begin
            occ = exp_q.size();
            chk("fifo_cnt", 32'(bus.fifo_cnt), 32'(occ));
            chk("kb_ready", 32'(bus.kb_ready), 32'(occ != 4));
            chk("irq_in", 32'(bus.irq_in), 32'(bus.fgi & bus.ien));
            if (bus.inpr_load) begin
                chk("load_while_fgi", 32'(bus.fgi), 32'd0);
                chk("load_spacing_ok", 32'((cyc - last_load) >= 3), 32'd1);
                exp_d = (occ != 0) ? 16'(exp_q.pop_front()) : 16'hxxxx;
                chk("inpr_data", 32'(bus.inpr_data), 32'(exp_d));
                last_load = cyc;
                last_data = bus.inpr_data;
                n_loads++;
            end
            if (bus.kb_valid && occ != 4)
                exp_q.push_back(bus.kb_data);
        end
    end

    // Drives send_q through the handshake; fgi_clr asserted with clr_pct % probability.
    task automatic run(input int cycles, input int clr_pct);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            bus.kb_valid = (send_q.size() != 0);
            if (bus.kb_valid)
                bus.kb_data = send_q[0];
            bus.fgi_clr = ($urandom_range(99) < clr_pct);
            @(negedge clk);
            acc = bus.kb_valid && bus.kb_ready;
            @(posedge clk);
            #1;
            if (acc)
                void'(send_q.pop_front());
        end
        bus.kb_valid = 1'b0;
        bus.fgi_clr  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int loads0;
        rst_n        = 1'b0;
        bus.kb_valid = 1'b0;
        bus.kb_data  = '0;
        bus.fgi_clr  = 1'b0;
        bus.ien      = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_fgi", 32'(bus.fgi), 32'd0);
        chk("rst_load", 32'(bus.inpr_load), 32'd0);
        chk("rst_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("rst_ready", 32'(bus.kb_ready), 32'd1);
        chk("rst_data", 32'(bus.inpr_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single character with exact latency
        bus.ien      = 1'b1;
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'h41;
        step();
        bus.kb_valid = 1'b0;
        chk("t2_e0_load", 32'(bus.inpr_load), 32'd0);
        chk("t2_e0_cnt", 32'(bus.fifo_cnt), 32'd1);
        step();
        chk("t2_e1_load", 32'(bus.inpr_load), 32'd1);
        chk("t2_e1_data", 32'(bus.inpr_data), 32'h0041);
        chk("t2_e1_fgi", 32'(bus.fgi), 32'd0);
        step();
        chk("t2_e2_load", 32'(bus.inpr_load), 32'd0);
        chk("t2_e2_fgi", 32'(bus.fgi), 32'd1);
        chk("t2_e2_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("t2_irq_on", 32'(bus.irq_in), 32'd1);
        bus.ien = 1'b0;
        #1;
        chk("t2_irq_off", 32'(bus.irq_in), 32'd0);
        bus.ien = 1'b1;
        run(3, 100);
        chk("t2_cleared", 32'(bus.fgi), 32'd0);

        // Back-pressure with FGI held
        loads0 = n_loads;
        for (int i = 0; i < 6; i++)
            send_q.push_back(8'h10 + 8'(i));
        run(12, 0);
        chk("t3_cnt", 32'(bus.fifo_cnt), 32'd4);
        chk("t3_ready", 32'(bus.kb_ready), 32'd0);
        chk("t3_fgi", 32'(bus.fgi), 32'd1);
        chk("t3_stalled", 32'(send_q.size()), 32'd1);
        chk("t3_loads", 32'(n_loads - loads0), 32'd1);
        chk("t3_first", 32'(last_data), 32'h0010);

        // Drain in order
        run(40, 100);
        chk("t4_sent", 32'(send_q.size()), 32'd0);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_loads", 32'(n_loads - loads0), 32'd6);
        chk("t4_last", 32'(last_data), 32'h0015);

        // Random release timing, pushes overlapping pops
        loads0 = n_loads;
        for (int i = 0; i < 20; i++)
            send_q.push_back(8'($urandom_range(255)));
        run(300, 40);
        run(3, 100);
        chk("t5_sent", 32'(send_q.size()), 32'd0);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_loads", 32'(n_loads - loads0), 32'd20);
        chk("t5_fgi", 32'(bus.fgi), 32'd0);

        // Spurious clear while idle and empty, then 0xFF
        bus.fgi_clr = 1'b1;
        step();
        step();
        bus.fgi_clr = 1'b0;
        chk("t6_fgi", 32'(bus.fgi), 32'd0);
        chk("t6_load", 32'(bus.inpr_load), 32'd0);
        chk("t6_cnt", 32'(bus.fifo_cnt), 32'd0);
        loads0 = n_loads;
        send_q.push_back(8'hFF);
        run(5, 0);
        chk("t6_loads", 32'(n_loads - loads0), 32'd1);
        chk("t6_data", 32'(last_data), 32'h00FF);
        chk("t6_fgi_set", 32'(bus.fgi), 32'd1);
        run(3, 100);

        // Reset in the middle of a LOAD with characters buffered
        send_q.push_back(8'h01);
        send_q.push_back(8'h02);
        send_q.push_back(8'h03);
        run(2, 0);
        chk("t1_midload", 32'(bus.inpr_load), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_fgi", 32'(bus.fgi), 32'd0);
        chk("t1_load", 32'(bus.inpr_load), 32'd0);
        chk("t1_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("t1_ready", 32'(bus.kb_ready), 32'd1);
        send_q.delete();
        step();
        rst_n = 1'b1;
        loads0 = n_loads;
        repeat (6) step();
        chk("t1_no_load", 32'(n_loads - loads0), 32'd0);
        chk("t1_post_cnt", 32'(bus.fifo_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
